// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_if
// Description : Instruction-memory request/response bundle between the fetch
//               stage (master) and the instruction memory (slave).
//               Request channel : imem_req_valid / imem_req_ready /
//                                 imem_req_addr
//               Response channel: imem_rsp_valid / imem_rsp_data (the memory
//                                 cannot be back-pressured)
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_if #(
    parameter int WORD_BITWIDTH = 32
);
    logic                     imem_req_valid;
    logic                     imem_req_ready;
    logic [WORD_BITWIDTH-1:0] imem_req_addr;
    logic                     imem_rsp_valid;
    logic [WORD_BITWIDTH-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage with a single outstanding memory
//               request, a one-entry skid buffer for responses that arrive
//               while the IF/ID register is stalled, and redirect handling
//               that discards an in-flight response.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               pc_hold             - suppress issuing new fetch requests
//               ifid_hold           - freeze the IF/ID register
//               redirect_valid/_pc  - taken branch/jump from a later stage
//               imem (fetch_if)     - instruction memory request/response
//               ifid_valid/_pc/_instr - IF/ID pipeline register
//               if_Rs1, if_Rs2      - source register fields of ifid_instr
//               perf_fetch_cnt, perf_bubble_cnt - only with FETCH_PERF_CNT_EN
// Options     : define FETCH_PERF_CNT_EN to build the performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int                       WORD_BITWIDTH    = 32,
    parameter int                       REG_NUM_BITWIDTH = 5,
    parameter logic [WORD_BITWIDTH-1:0] RESET_PC         = 32'h0000_0000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        pc_hold,
    input  logic                        ifid_hold,
    input  logic                        redirect_valid,
    input  logic [WORD_BITWIDTH-1:0]    redirect_pc,
    fetch_if.master                     imem,
    output logic                        ifid_valid,
    output logic [WORD_BITWIDTH-1:0]    ifid_pc,
    output logic [WORD_BITWIDTH-1:0]    ifid_instr,
    output logic [REG_NUM_BITWIDTH-1:0] if_Rs1,
    output logic [REG_NUM_BITWIDTH-1:0] if_Rs2
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                 perf_fetch_cnt,
    output logic [31:0]                 perf_bubble_cnt
`endif
);

    // addi x0, x0, 0 : the canonical bubble instruction
    localparam logic [WORD_BITWIDTH-1:0] NOP_INSTR = WORD_BITWIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // ready to issue a request
        S_WAIT = 2'd1,  // request accepted, awaiting the response
        S_FULL = 2'd2,  // response parked in the buffer behind a stalled IF/ID
        S_DROP = 2'd3   // response still in flight but made stale by a redirect
    } state_t;

    state_t                   state, state_nxt;
    logic [WORD_BITWIDTH-1:0] pc, pc_nxt;
    logic [WORD_BITWIDTH-1:0] req_pc, req_pc_nxt;
    logic [WORD_BITWIDTH-1:0] buf_pc, buf_pc_nxt;
    logic [WORD_BITWIDTH-1:0] buf_instr, buf_instr_nxt;

    logic                     load_valid;
    logic                     load_bubble;
    logic [WORD_BITWIDTH-1:0] load_pc;
    logic [WORD_BITWIDTH-1:0] load_instr;
    logic                     req_fire;

    // ------------------------------------------------------------------
    // Request channel
    // ------------------------------------------------------------------
    assign imem.imem_req_valid = (state == S_REQ) & ~pc_hold & ~redirect_valid;
    assign imem.imem_req_addr  = pc;
    assign req_fire            = imem.imem_req_valid & imem.imem_req_ready;

    // ------------------------------------------------------------------
    // Next-state and IF/ID load decisions
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        req_pc_nxt    = req_pc;
        buf_pc_nxt    = buf_pc;
        buf_instr_nxt = buf_instr;
        load_valid    = 1'b0;
        load_bubble   = 1'b0;
        load_pc       = buf_pc;
        load_instr    = buf_instr;

        if (redirect_valid) begin
            // Masking the low bits keeps the target word aligned.
            pc_nxt = redirect_pc & ~WORD_BITWIDTH'(3);
            case (state)
                S_WAIT:  state_nxt = imem.imem_rsp_valid ? S_REQ : S_DROP;
                S_DROP:  state_nxt = imem.imem_rsp_valid ? S_REQ : S_DROP;
                default: state_nxt = S_REQ;
            endcase
            // A fresh redirect flushes IF/ID even under ifid_hold. A repeat
            // redirect while already dropping only retargets the pc; IF/ID
            // then follows the ordinary bubble/hold rule.
            if (state != S_DROP) begin
                load_bubble = 1'b1;
            end else begin
                load_bubble = ~ifid_hold;
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (req_fire) begin
                        req_pc_nxt = pc;
                        pc_nxt     = pc + WORD_BITWIDTH'(4);
                        state_nxt  = S_WAIT;
                    end
                    // Responses arriving here are protocol violations: ignored.
                    load_bubble = ~ifid_hold;
                end
                S_WAIT: begin
                    if (imem.imem_rsp_valid) begin
                        if (!ifid_hold) begin
                            load_valid = 1'b1;
                            load_pc    = req_pc;
                            load_instr = imem.imem_rsp_data;
                            state_nxt  = S_REQ;
                        end else begin
                            buf_pc_nxt    = req_pc;
                            buf_instr_nxt = imem.imem_rsp_data;
                            state_nxt     = S_FULL;
                        end
                    end else begin
                        load_bubble = ~ifid_hold;
                    end
                end
                S_FULL: begin
                    // Drain the buffer; issuing waits for the next cycle.
                    if (!ifid_hold) begin
                        load_valid = 1'b1;
                        state_nxt  = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem.imem_rsp_valid) begin
                        state_nxt = S_REQ;
                    end
                    load_bubble = ~ifid_hold;
                end
                default: state_nxt = S_REQ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            req_pc    <= '0;
            buf_pc    <= '0;
            buf_instr <= NOP_INSTR;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            req_pc    <= req_pc_nxt;
            buf_pc    <= buf_pc_nxt;
            buf_instr <= buf_instr_nxt;
        end
    end

    // IF/ID register: a bubble clears valid and inserts a NOP but keeps pc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_valid <= 1'b0;
            ifid_pc    <= '0;
            ifid_instr <= NOP_INSTR;
        end else if (load_valid) begin
            ifid_valid <= 1'b1;
            ifid_pc    <= load_pc;
            ifid_instr <= load_instr;
        end else if (load_bubble) begin
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
        end
    end

    assign if_Rs1 = ifid_instr[15 +: REG_NUM_BITWIDTH];
    assign if_Rs2 = ifid_instr[20 +: REG_NUM_BITWIDTH];

`ifdef FETCH_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters (free-running, wrap at 2^32)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt  <= 32'd0;
            perf_bubble_cnt <= 32'd0;
        end else begin
            if (load_valid) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (load_bubble && !load_valid) begin
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter WORD_BITWIDTH, default 32, instruction/address width.
REQ-002 SHALL have parameter REG_NUM_BITWIDTH, default 5, register-number width.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pc_hold  input  1  hazard stall: no new fetch request issued while high.
REQ-007 SHALL have port ifid_hold  input  1  hazard stall: IF/ID register keeps its contents while high.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump taken in a later stage.
REQ-009 SHALL have port redirect_pc  input  WORD_BITWIDTH  redirect target.
REQ-010 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-011 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-012 SHALL have port imem_req_addr  output  WORD_BITWIDTH  fetch address.
REQ-013 SHALL have port imem_rsp_valid  input  1  instruction word returned; no backpressure.
REQ-014 SHALL have port imem_rsp_data  input  WORD_BITWIDTH  instruction word.
REQ-015 SHALL have ports ifid_valid (1), ifid_pc (WORD_BITWIDTH), ifid_instr (WORD_BITWIDTH) as outputs: IF/ID register.
REQ-016 SHALL have ports if_Rs1, if_Rs2  output  REG_NUM_BITWIDTH  ifid_instr[19:15], ifid_instr[24:20], combinational, for hazard detection.

Function
REQ-017 SHALL implement FSM states REQ, WAIT, FULL, DROP with at most one outstanding request.
REQ-018 SHALL drive imem_req_valid = (state==REQ) & ~pc_hold & ~redirect_valid, imem_req_addr = pc.
REQ-019 SHALL on request handshake latch req_pc <= pc, pc <= pc+4 (modulo 2^WORD_BITWIDTH), go WAIT.
REQ-020 SHALL in WAIT on imem_rsp_valid: if ~ifid_hold load IF/ID {1, req_pc, rsp_data} and go REQ; else store {req_pc, rsp_data} in one-entry buffer and go FULL.
REQ-021 SHALL in FULL, when ifid_hold drops, load buffer into IF/ID (valid=1) and go REQ; same-cycle request issue not allowed from FULL.
REQ-022 SHALL load a bubble (valid=0, instr=32'h0000_0013, pc unchanged) into IF/ID on any cycle with ifid_hold low and no instruction delivered.
REQ-023 SHALL give redirect_valid priority over all else: pc <= {redirect_pc[WORD_BITWIDTH-1:2], 2'b00}, IF/ID <= bubble, buffer emptied, regardless of ifid_hold.
REQ-024 SHALL on redirect go DROP if in WAIT without same-cycle imem_rsp_valid; otherwise go REQ.
REQ-025 SHALL in DROP discard the next imem_rsp_valid word and go REQ; a further redirect in DROP updates pc only.
REQ-026 SHALL ignore imem_rsp_valid in REQ and FULL (protocol violation, no state change).
REQ-027 SHALL keep pc unchanged while pc_hold is high in REQ; ifid_hold alone does not block issue.

Reset
REQ-028 SHALL on rst_n low asynchronously set pc=RESET_PC, req_pc=0, state=REQ, buffer empty.
REQ-029 SHALL reset ifid_valid=0, ifid_pc=0, ifid_instr=32'h0000_0013; imem_req_valid follows REQ-018 once rst_n high.
REQ-030 SHALL treat reset mid-transaction as abandoning the outstanding request; a late response after reset lands in REQ and is ignored per REQ-026.

Configuration
REQ-031 SHALL compile perf counters when macro FETCH_PERF_CNT_EN is defined: outputs perf_fetch_cnt, perf_bubble_cnt, 32 bits each.
REQ-032 SHALL with FETCH_PERF_CNT_EN increment perf_fetch_cnt per valid IF/ID load and perf_bubble_cnt per bubble load, wrapping at 2^32, reset to 0.
REQ-033 SHALL without FETCH_PERF_CNT_EN omit both ports and counters; all other behaviour identical.

Verification
REQ-034 SHALL cover reset then zero-wait memory (ready=1, rsp next cycle): addresses 0x0,0x4,0x8 issued every 2 cycles; IF/ID pc 0x0,0x4,0x8, valid=1.
REQ-035 SHALL cover ifid_hold high 3 cycles while response arrives: response buffered (FULL), IF/ID unchanged, word appears in IF/ID the cycle after hold drops, no request during FULL.
REQ-036 SHALL cover redirect_valid to 0x103 in WAIT: pending response discarded (DROP), next request addr 0x100, IF/ID bubble instr 0x00000013.
REQ-037 SHALL cover redirect and imem_rsp_valid same cycle in WAIT: response dropped, state REQ next cycle, request to target.
REQ-038 SHALL cover pc_hold high with imem_req_ready=1 for 4 cycles: imem_req_valid=0, pc stable; with FETCH_PERF_CNT_EN, perf_bubble_cnt rises by cycles of bubble load.
